// File: rtl/alu_seq.sv
// alu_seq: clocked WIDTH-bit ALU with a persistent {V,N,Z,C} flag register, a start/busy/done
// handshake and bit-serial shifts/rotates. Define ALU_SEQ_MUL_EN to add the shift-add multiply (opcode 10000).
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       control,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    output logic [WIDTH-1:0] o,
    output logic [3:0]       status,
    output logic             busy,
    output logic             done
);
    localparam int               SH_W    = $clog2(WIDTH);
    localparam int               MSB     = WIDTH - 1;
    localparam logic [WIDTH-1:0] W_V     = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] W_CNT   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_OR   = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_NOT  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SAR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_PASS = 5'b01011;
    localparam logic [4:0] OP_CLR  = 5'b01100;
    localparam logic [4:0] OP_ADC  = 5'b01110;
    localparam logic [4:0] OP_SBC  = 5'b01111;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [4:0] OP_MUL  = 5'b10000;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [4:0] op);
        is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR) ||
                   (op == OP_ROL) || (op == OP_ROR);
    endfunction

    // Linear shifts saturate at WIDTH steps; rotates wrap modulo WIDTH.
    function automatic logic [CNT_W-1:0] shift_count(input logic [4:0] op, input logic [WIDTH-1:0] amt);
        if ((op == OP_ROL) || (op == OP_ROR))
            shift_count = {1'b0, amt[SH_W-1:0]};
        else if (amt >= W_V)
            shift_count = W_CNT;
        else
            shift_count = amt[CNT_W-1:0];
    endfunction

    // Returns {bit shifted out, shifted value} for one step.
    function automatic logic [WIDTH:0] shift_step(input logic [4:0] op, input logic [WIDTH-1:0] v);
        case (op)
            OP_SHL:  shift_step = {v, 1'b0};
            OP_SHR:  shift_step = {v[0], 1'b0, v[WIDTH-1:1]};
            OP_SAR:  shift_step = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            OP_ROL:  shift_step = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            default: shift_step = {v[0], v[0], v[WIDTH-1:1]};
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic [3:0]       status_q, status_d;
    logic             done_q, done_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]   mul_sum;
`endif

    logic [WIDTH-1:0] step_o;
    logic             step_c;
    logic [WIDTH:0]   arith;
    logic [WIDTH-1:0] res;
    logic             res_c, res_v, legal, cin;
    logic [WIDTH-1:0] fin_o;
    logic [3:0]       fin_st;

    // Single-cycle result, evaluated in FIN from the captured operands.
    always_comb begin
        arith = '0;
        res   = '0;
        res_c = status_q[0];
        res_v = 1'b0;
        legal = 1'b1;
        cin   = status_q[0] & ((op_q == OP_ADC) || (op_q == OP_SBC));
        case (op_q)
            OP_ADD, OP_ADC: begin
                arith = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
                res   = arith[WIDTH-1:0];
                res_c = arith[WIDTH];
                res_v = (a_q[MSB] == b_q[MSB]) && (res[MSB] != a_q[MSB]);
            end
            OP_SUB, OP_SBC: begin
                arith = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin};
                res   = arith[WIDTH-1:0];
                res_c = arith[WIDTH];
                res_v = (a_q[MSB] != b_q[MSB]) && (res[MSB] != a_q[MSB]);
            end
            OP_OR:   res = a_q | b_q;
            OP_AND:  res = a_q & b_q;
            OP_XOR:  res = a_q ^ b_q;
            OP_NOT:  res = ~b_q;
            OP_PASS: res = b_q;
            OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: res = a_q;
            OP_CLR:  res_c = 1'b0;
            default: legal = 1'b0;
        endcase
        fin_o  = res;
        fin_st = legal ? {res_v, res[MSB], ~|res, res_c} : status_q;
    end

    always_comb begin
        state_d  = state_q;
        o_d      = o_q;
        status_d = status_q;
        done_d   = 1'b0;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d    = acc_q;
        mul_sum  = '0;
`endif
        step_o   = '0;
        step_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = control;
                    a_d     = a1;
                    b_d     = a2;
                    cnt_d   = shift_count(control, a2);
                    state_d = S_FIN;
                    if (is_shift(control) && (cnt_d != '0))
                        state_d = S_ITER;
`ifdef ALU_SEQ_MUL_EN
                    if (control == OP_MUL) begin
                        cnt_d   = W_CNT;
                        acc_d   = '0;
                        state_d = S_ITER;
                    end
`endif
                end
            end
            S_ITER: begin
                cnt_d = cnt_q - CNT_ONE;
`ifdef ALU_SEQ_MUL_EN
                if (op_q == OP_MUL) begin
                    // {acc, b} shifts right one place per step; b ends as the low product half.
                    mul_sum = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
                    acc_d   = mul_sum[WIDTH:1];
                    b_d     = {mul_sum[0], b_q[WIDTH-1:1]};
                    step_o  = b_d;
                    step_c  = |acc_d;
                end else
`endif
                begin
                    {step_c, step_o} = shift_step(op_q, a_q);
                    a_d = step_o;
                end
                // The last step writes back directly, so n steps finish n edges after acceptance.
                if (cnt_q == CNT_ONE) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    o_d      = step_o;
                    status_d = {1'b0, step_o[MSB], ~|step_o, step_c};
                end
            end
            S_FIN: begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                o_d      = fin_o;
                status_d = fin_st;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            o_q      <= '0;
            status_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            o_q      <= o_d;
            status_q <= status_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q  <= op_d;
        a_q   <= a_d;
        b_q   <= b_d;
        cnt_q <= cnt_d;
`ifdef ALU_SEQ_MUL_EN
        acc_q <= acc_d;
`endif
    end

    assign o      = o_q;
    assign status = status_q;
    assign done   = done_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=8): directed vector table, hand-written handshake/reset
// sequences and randomized operations against a behavioural model.
module tb_alu_seq;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);
    localparam int FULL = 1 << W;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_OR   = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_NOT  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SAR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_PASS = 5'b01011;
    localparam logic [4:0] OP_CLR  = 5'b01100;
    localparam logic [4:0] OP_ILL  = 5'b01101;
    localparam logic [4:0] OP_ADC  = 5'b01110;
    localparam logic [4:0] OP_SBC  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_ILL2 = 5'b11111;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [4:0]   control;
    logic [W-1:0] a1, a2, o;
    logic [3:0]   status;
    logic         busy, done;

    int         tests = 0;
    int         fails = 0;
    logic [3:0] mstat;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] eo;
        logic [3:0]   es;
        int           edges;
    } vec_t;
    vec_t vecs[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .control(control),
        .a1(a1), .a2(a2), .o(o), .status(status), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, got, exp);
        end
    endtask

    task automatic add_vec(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] eo, input logic [3:0] es, input int e);
        vec_t v;
        v.op = op; v.x = x; v.y = y; v.eo = eo; v.es = es; v.edges = e;
        vecs.push_back(v);
    endtask

    // Reference behaviour from the opcode rules, in plain integer arithmetic.
    function automatic void model(input logic [4:0] op, input int x, input int y, input logic [3:0] st,
                                  output int eo, output logic [3:0] es, output int edges);
        int r, n, sx, sy, s, cin;
        bit legal, c, v;
        r = 0; n = 0; s = 0; legal = 1'b1; c = st[0]; v = 1'b0; edges = 2;
        sx  = (x >= HALF) ? x - FULL : x;
        sy  = (y >= HALF) ? y - FULL : y;
        cin = ((op == OP_ADC) || (op == OP_SBC)) ? int'(st[0]) : 0;
        case (op)
            OP_ADD, OP_ADC: begin
                r = x + y + cin; c = (r > MASK);
                s = sx + sy + cin; v = (s >= HALF) || (s < -HALF);
            end
            OP_SUB, OP_SBC: begin
                r = x - y - cin; c = (x < y + cin);
                s = sx - sy - cin; v = (s >= HALF) || (s < -HALF);
            end
            OP_OR:   r = x | y;
            OP_AND:  r = x & y;
            OP_XOR:  r = x ^ y;
            OP_NOT:  r = ~y;
            OP_PASS: r = y;
            OP_CLR:  begin r = 0; c = 1'b0; end
            OP_SHL, OP_SHR, OP_SAR: begin
                n = (y > W) ? W : y;
                r = x;
                if (n > 0) begin
                    if (op == OP_SHL) begin
                        r = x << n; c = ((x >> (W - n)) & 1) != 0;
                    end else if (op == OP_SHR) begin
                        r = x >> n; c = ((x >> (n - 1)) & 1) != 0;
                    end else begin
                        r = sx >>> n; c = ((sx >>> (n - 1)) & 1) != 0;
                    end
                end
                edges = (n == 0) ? 2 : n + 1;
            end
            OP_ROL, OP_ROR: begin
                n = y % W;
                r = x;
                if (n > 0) begin
                    if (op == OP_ROL) begin
                        r = ((x << n) | (x >> (W - n))) & MASK; c = (r & 1) != 0;
                    end else begin
                        r = ((x >> n) | (x << (W - n))) & MASK; c = ((r >> (W - 1)) & 1) != 0;
                    end
                end
                edges = (n == 0) ? 2 : n + 1;
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                r = x * y; c = (r >> W) != 0; edges = W + 1;
            end
`endif
            default: legal = 1'b0;
        endcase
        r = r & MASK;
        eo = legal ? r : 0;
        es = legal ? {v, ((r >> (W - 1)) & 1) != 0, r == 0, c} : st;
    endfunction

    // Issues one operation, scrambles the inputs while busy, and waits (bounded) for done.
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] ro, output logic [3:0] rs, output int edges, output int bcyc);
        @(negedge clk);
        start = 1'b1; control = op; a1 = x; a2 = y;
        @(negedge clk);
        start = 1'b0; edges = 1; bcyc = 0;
        while (!done && edges < 40) begin
            if (busy) bcyc++;
            a1 = W'($urandom); a2 = W'($urandom); control = 5'($urandom);
            @(negedge clk);
            edges++;
        end
        if (!done) check("done_timeout", int'(op), 0, 1);
        ro = o; rs = status;
    endtask

    initial begin
        logic [W-1:0] go, rx, ry;
        logic [3:0]   gs, es;
        logic [4:0]   rop;
        int           ge, gb, eo, ee, ndone;

        rst = 1'b1; start = 1'b0; control = '0; a1 = '0; a2 = '0;
        repeat (2) @(negedge clk);
        check("rst_o", 0, int'(o), 0);
        check("rst_status", 0, int'(status), 0);
        check("rst_busy", 0, int'(busy), 0);
        check("rst_done", 0, int'(done), 0);
        rst = 1'b0;
        mstat = 4'b0000;

        add_vec(OP_ADD,  8'hFF, 8'h01, 8'h00, 4'b0011, 2);
        add_vec(OP_ADC,  8'h10, 8'h20, 8'h31, 4'b0000, 2);
        add_vec(OP_SUB,  8'h05, 8'h07, 8'hFE, 4'b0101, 2);
        add_vec(OP_ADD,  8'h7F, 8'h01, 8'h80, 4'b1100, 2);
        add_vec(OP_ROL,  8'h81, 8'h03, 8'h0C, 4'b0000, 4);
        add_vec(OP_SAR,  8'h80, 8'h09, 8'hFF, 4'b0101, 9);
        add_vec(OP_SHL,  8'h5A, 8'h00, 8'h5A, 4'b0001, 2);
        add_vec(OP_ILL,  8'h33, 8'h44, 8'h00, 4'b0001, 2);
        add_vec(OP_CLR,  8'h12, 8'h34, 8'h00, 4'b0010, 2);
        add_vec(OP_SBC,  8'h00, 8'h01, 8'hFF, 4'b0101, 2);
        add_vec(OP_SBC,  8'h80, 8'h00, 8'h7F, 4'b1000, 2);
        add_vec(OP_ROR,  8'h01, 8'h09, 8'h80, 4'b0101, 2);
        add_vec(OP_XOR,  8'hFF, 8'h0F, 8'hF0, 4'b0101, 2);
        add_vec(OP_NOT,  8'h00, 8'hFF, 8'h00, 4'b0011, 2);
        add_vec(OP_PASS, 8'h00, 8'h80, 8'h80, 4'b0101, 2);
        add_vec(OP_SHL,  8'h81, 8'h08, 8'h00, 4'b0011, 9);
        add_vec(OP_SHR,  8'h81, 8'hC8, 8'h00, 4'b0011, 9);
        add_vec(OP_AND,  8'h0F, 8'hF3, 8'h03, 4'b0001, 2);
        add_vec(OP_OR,   8'hF0, 8'h0F, 8'hFF, 4'b0101, 2);
        add_vec(OP_ILL2, 8'hAA, 8'h55, 8'h00, 4'b0101, 2);
`ifdef ALU_SEQ_MUL_EN
        add_vec(OP_MUL,  8'h0D, 8'h0B, 8'h8F, 4'b0100, 9);
        add_vec(OP_MUL,  8'h10, 8'h10, 8'h00, 4'b0011, 9);
`else
        add_vec(OP_MUL,  8'h0D, 8'h0B, 8'h00, 4'b0101, 2);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].x, vecs[i].y, go, gs, ge, gb);
            check("vec_o", i, int'(go), int'(vecs[i].eo));
            check("vec_status", i, int'(gs), int'(vecs[i].es));
            check("vec_edges", i, ge, vecs[i].edges);
            check("vec_busy", i, gb, vecs[i].edges - 1);
            mstat = vecs[i].es;
        end

        // start pulsed while a shift is in flight must be ignored
        @(negedge clk);
        start = 1'b1; control = OP_SHR; a1 = 8'hF0; a2 = 8'h04;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; control = OP_ADD; a1 = 8'h01; a2 = 8'h01;
        @(negedge clk);
        start = 1'b0;
        ge = 3;
        while (!done && ge < 40) begin
            @(negedge clk);
            ge++;
        end
        check("busy_ign_edges", 0, ge, 5);
        check("busy_ign_o", 0, int'(o), 8'h0F);
        check("busy_ign_status", 0, int'(status), 4'b0000);
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("busy_ign_extra_done", 0, ndone, 0);
        check("busy_ign_o_hold", 0, int'(o), 8'h0F);

        // reset during ITER aborts without a done pulse
        run_op(OP_ADD, 8'h7F, 8'h01, go, gs, ge, gb);
        check("pre_rst_o", 0, int'(go), 8'h80);
        @(negedge clk);
        start = 1'b1; control = OP_SHL; a1 = 8'hFF; a2 = 8'h06;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_o", 0, int'(o), 0);
        check("mid_rst_status", 0, int'(status), 0);
        check("mid_rst_busy", 0, int'(busy), 0);
        check("mid_rst_done", 0, int'(done), 0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid_rst_no_done", 0, ndone, 0);
        mstat = 4'b0000;

        for (int i = 0; i < 300; i++) begin
            rop = 5'($urandom_range(0, 17));
            if ($urandom_range(0, 9) == 0) rop = 5'($urandom_range(18, 31));
            rx = W'($urandom);
            ry = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 10)) : W'($urandom);
            model(rop, int'(rx), int'(ry), mstat, eo, es, ee);
            run_op(rop, rx, ry, go, gs, ge, gb);
            check("rnd_o", i, int'(go), eo);
            check("rnd_status", i, int'(gs), int'(es));
            check("rnd_edges", i, ge, ee);
            mstat = es;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
